blink_sequencer: RTL

//  Consumer of the countdown timer's 1-cycle done pulse (the "tick").

---
 rtl/blink_pkg.sv | 16 +
 rtl/blink_sequencer_tick_counter.sv | 27 ++
 rtl/blink_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink sequencer: FSM state encoding and counter widths.
// The state encoding is also what drives the board's debug LEDs.
package blink_pkg;

    localparam int STATE_W = 2;
    localparam int BLINK_W = 3;
    localparam int PAUSE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_ON    = 2'd1,
        S_OFF   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

endpackage

// File: rtl/blink_sequencer_tick_counter.sv
// Small up-counter with synchronous clear (clear beats inc).
// Used for both the blink count and the pause count.
module tick_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (clear) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/blink_sequencer.sv
// Blink FSM stepped by the timer's tick pulse: bursts of ON/OFF blinks separated
// by a dark pause, or continuous blinking when burst_len is zero.
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int PAUSE_TICKS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               tick,
    input  logic [2:0]         burst_len,
    output logic               led,
    output logic               burst_done,
    output logic [STATE_W-1:0] state
);

    state_t             r_state;
    logic               r_led;
    logic               r_burst_done;
    logic [BLINK_W-1:0] r_len_q;

    state_t             w_state_next;
    logic               w_burst_done_next;
    logic               w_len_load;
    logic               w_blink_clr;
    logic               w_blink_inc;
    logic               w_pause_clr;
    logic               w_pause_inc;
    logic [BLINK_W-1:0] w_blink_cnt;
    logic [PAUSE_W-1:0] w_pause_cnt;
    logic               w_burst_end;
    logic               w_pause_end;

    assign w_burst_end = (r_len_q != '0) && (w_blink_cnt == r_len_q);
    assign w_pause_end = (w_pause_cnt == PAUSE_W'(PAUSE_TICKS - 1));

    always_comb begin
        w_state_next      = r_state;
        w_burst_done_next = 1'b0;
        w_len_load        = 1'b0;
        w_blink_clr       = 1'b0;
        w_blink_inc       = 1'b0;
        w_pause_clr       = 1'b0;
        w_pause_inc       = 1'b0;

        if (!enable) begin
            w_state_next = S_IDLE;
            w_blink_clr  = 1'b1;
            w_pause_clr  = 1'b1;
        end else if (tick) begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_ON;
                    w_len_load   = 1'b1;
                    w_blink_clr  = 1'b1;
                end
                S_ON: begin
                    w_state_next = S_OFF;
                    // Continuous mode keeps the count pinned at zero so it never wraps.
                    w_blink_inc  = (r_len_q != '0);
                end
                S_OFF: begin
                    if (w_burst_end) begin
                        w_state_next      = S_PAUSE;
                        w_pause_clr       = 1'b1;
                        w_burst_done_next = 1'b1;
                    end else begin
                        w_state_next = S_ON;
                    end
                end
                S_PAUSE: begin
                    if (w_pause_end) begin
                        w_state_next = S_ON;
                        w_len_load   = 1'b1;
                        w_blink_clr  = 1'b1;
                        w_pause_clr  = 1'b1;
                    end else begin
                        w_pause_inc = 1'b1;
                    end
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_led        <= 1'b0;
            r_burst_done <= 1'b0;
            r_len_q      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_led        <= (w_state_next == S_ON);
            r_burst_done <= w_burst_done_next;
            if (w_len_load) begin
                r_len_q <= burst_len;
            end
        end
    end

    tick_counter #(.WIDTH(BLINK_W)) u_blink_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (w_blink_clr),
        .inc   (w_blink_inc),
        .q     (w_blink_cnt)
    );

    tick_counter #(.WIDTH(PAUSE_W)) u_pause_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (w_pause_clr),
        .inc   (w_pause_inc),
        .q     (w_pause_cnt)
    );

    assign led        = r_led;
    assign burst_done = r_burst_done;
    assign state      = r_state;

endmodule
